uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver, the successor to the fixed 8N1 byte receiver.
- Configurable data width, parity mode and stop-bit count; runtime baud select.
- 16x oversampling with 3-sample majority vote; start-glitch rejection; per-frame parity and framing error flags.
- Sits between the board RX pin and any byte consumer, e.g. a command parser or FIFO.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked, legal 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- baud_set  input  3  0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200, 5..7 = 9600.
- rs232_rx  input  1  serial line, idle high, asynchronous to clk.
- data_out  output  DATA_BITS  last received word, LSB first on the line.
- data_valid  output  1  one-cycle pulse, frame complete.
- parity_err  output  1  qualified by data_valid.
- frame_err  output  1  qualified by data_valid.
- rx_busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset: all outputs 0. FSM to IDLE. Synchroniser flops to 1. Counters 0.
- rst asserted mid-frame aborts the frame with no data_valid. Reception restarts on the next falling edge after release.
- Synchroniser: 2 flops on rs232_rx, plus a third flop for edge detection.
- Tick generator: div = CLK_FREQ/(baud*16) - 1, truncated, computed from a constant table.
  - One-cycle tick when the counter reaches div, then the counter wraps to 0.
  - Counter is cleared on start-edge detection, so tick phase aligns to the frame.
  - baud_set is latched at start detection; changes mid-frame are ignored.
  - Example: 9600 at 50 MHz gives div = 324, i.e. 5200 clk per bit.
- Sampling: per bit, tick index 0..15. Samples are taken at ticks 7, 8, 9; the bit value is the majority of the three. The bit ends at tick 15.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on synchronised falling edge, go to START and assert rx_busy.
  - START: majority = 1 means false start; return to IDLE, deassert rx_busy, no pulse. Majority = 0 means go to DATA at the end of the bit.
  - DATA: shift DATA_BITS bits LSB first. Bit counter 0..DATA_BITS-1. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: even mode expects XOR(data, parity bit) = 0; odd mode expects 1. A mismatch latches an internal parity flag.
  - STOP: each of STOP_BITS bits must have majority 1, else latch an internal framing flag.
- Frame completion: on tick 9 of the last stop bit, go to IDLE. Do not wait for end of bit; this allows back-to-back frames.
- One cycle later: data_out updates, data_valid = 1 for exactly 1 clk, and parity_err/frame_err present the latched flags for that same cycle (0 otherwise). rx_busy drops in the same cycle.
- data_valid pulses even on error. data_out holds until the next completed frame.
- A line held low (break) yields frame_err with data 0. A new frame needs a rising then falling edge.
- Latency: data_valid 1 clk after the mid-sample of the final stop bit.

Decomposition:
- Package uart_pkg:
  - baud table (baud_set to divisor function of CLK_FREQ);
  - PARITY_NONE/EVEN/ODD constants;
  - FSM state encoding;
  - OVERSAMPLE = 16; SAMPLE_LO/MID/HI = 7/8/9.
- Sub-module uart_baud_tick: clk, rst, clear, baud_set latched, tick out. Reusable by a future parametrised transmitter.

Test Plan:
- 8N1, baud_set 0, bench transmitter at 5208 clk/bit sends 8'h18 → single data_valid, data_out 8'h18, both errors 0; rx_busy high ~52,000 clk.
- baud_set 4, back-to-back 8'h55 then 8'hAA with zero idle gap → two data_valid pulses, values 8'h55 then 8'hAA, no errors.
- rs232_rx low for 3 clk then high, baud_set 0 → no data_valid; rx_busy returns to 0 within one bit time.
- PARITY_MODE 1, DATA_BITS 7: send 7'h07 with parity bit 0 → data_valid, data_out 7'h07, parity_err 1. Correct parity bit 1 → parity_err 0.
- STOP_BITS 2, second stop bit driven 0 → frame_err 1, data intact; next normal frame 8'h3C has frame_err 0.
- rst pulsed mid-DATA of 8'hF0 → outputs 0, no pulse; subsequent 8'h81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM encoding and baud divisor table for the
//               parametrised UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  SAMPLE_LO  = 4'd7;
    localparam logic [3:0]  SAMPLE_MID = 4'd8;
    localparam logic [3:0]  SAMPLE_HI  = 4'd9;
    localparam logic [3:0]  TICK_LAST  = 4'd15;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        case (sel)
            3'd1:    return 19200;
            3'd2:    return 38400;
            3'd3:    return 57600;
            3'd4:    return 115200;
            default: return 9600;
        endcase
    endfunction

    // Evaluated only with constant arguments, so no divider is ever built.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
        return clk_freq / (baud_rate(sel) * OVERSAMPLE) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : 16x oversampling tick generator with a constant divisor table
//               and a synchronous phase clear.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic [2:0] i_baud_set,
    output logic       o_tick
);

    localparam int unsigned c_div_max = baud_div(CLK_FREQ, 3'd0);
    localparam int          c_cnt_w   = (c_div_max < 1) ? 1 : $clog2(c_div_max + 1);

    localparam logic [c_cnt_w-1:0] c_div_9600   = c_cnt_w'(baud_div(CLK_FREQ, 3'd0));
    localparam logic [c_cnt_w-1:0] c_div_19200  = c_cnt_w'(baud_div(CLK_FREQ, 3'd1));
    localparam logic [c_cnt_w-1:0] c_div_38400  = c_cnt_w'(baud_div(CLK_FREQ, 3'd2));
    localparam logic [c_cnt_w-1:0] c_div_57600  = c_cnt_w'(baud_div(CLK_FREQ, 3'd3));
    localparam logic [c_cnt_w-1:0] c_div_115200 = c_cnt_w'(baud_div(CLK_FREQ, 3'd4));

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_div;
    logic               w_wrap;

    always_comb begin
        case (i_baud_set)
            3'd1:    w_div = c_div_19200;
            3'd2:    w_div = c_div_38400;
            3'd3:    w_div = c_div_57600;
            3'd4:    w_div = c_div_115200;
            default: w_div = c_div_9600;
        endcase
    end

    // >= keeps the counter bounded if the divisor shrinks under a running count.
    assign w_wrap = (r_cnt >= w_div);
    assign o_tick = w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver, 16x oversampling with 3-sample
//               majority vote, parity and framing error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int          DATA_BITS   = 8,
    parameter int          PARITY_MODE = 0,
    parameter int          STOP_BITS   = 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           baud_set,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam logic [3:0] c_last_data  = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_last_stop  = 4'(STOP_BITS - 1);
    localparam logic       c_par_expect = (PARITY_MODE == PARITY_EVEN) ? 1'b0 : 1'b1;

    logic                 r_sync1, r_sync2, r_sync3;
    logic [2:0]           r_state, w_next;
    logic [2:0]           r_baud_sel;
    logic [3:0]           r_tick_idx, r_bit_cnt;
    logic                 r_s_lo, r_s_mid;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr;
    logic                 w_tick, w_fall, w_maj;
    logic                 w_start, w_sample, w_bit_end, w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rs232_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall = r_sync3 & ~r_sync2;
    // Third vote is the live sample taken on the SAMPLE_HI tick itself.
    assign w_maj  = (r_s_lo & r_s_mid) | (r_s_lo & r_sync2) | (r_s_mid & r_sync2);

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ)
    ) u_baud_tick (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_start),
        .i_baud_set (r_baud_sel),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_sample && w_maj) w_next = S_IDLE;
                      else if (w_bit_end)    w_next = S_DATA;
            S_DATA:   if (w_bit_end && (r_bit_cnt == c_last_data))
                          w_next = (PARITY_MODE != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next = S_STOP;
            S_STOP:   if (w_done) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (r_state != S_IDLE);
        w_start   = (r_state == S_IDLE) && w_fall;
        w_sample  = w_tick && (r_tick_idx == SAMPLE_HI) && rx_busy;
        w_bit_end = w_tick && (r_tick_idx == TICK_LAST);
        // Leave on the final stop mid-sample so a back-to-back start edge is not missed.
        w_done    = (r_state == S_STOP) && w_sample && (r_bit_cnt == c_last_stop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_sel <= 3'd0;
            r_tick_idx <= 4'd0;
            r_bit_cnt  <= 4'd0;
            r_s_lo     <= 1'b1;
            r_s_mid    <= 1'b1;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_start) begin
                r_baud_sel <= baud_set;
                r_tick_idx <= 4'd0;
                r_bit_cnt  <= 4'd0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
            end else begin
                if (w_tick && rx_busy)
                    r_tick_idx <= r_tick_idx + 4'd1;
                if (w_bit_end && (r_state == S_DATA))
                    r_bit_cnt <= (r_bit_cnt == c_last_data) ? 4'd0 : r_bit_cnt + 4'd1;
                else if (w_bit_end && (r_state == S_STOP))
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                if (w_sample) begin
                    case (r_state)
                        S_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                        S_PARITY: r_perr  <= ((^r_shift) ^ w_maj) != c_par_expect;
                        S_STOP:   if (!w_maj) r_ferr <= 1'b1;
                        default:  ;
                    endcase
                end
            end
            if (w_tick && (r_tick_idx == SAMPLE_LO))  r_s_lo  <= r_sync2;
            if (w_tick && (r_tick_idx == SAMPLE_MID)) r_s_mid <= r_sync2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= w_done;
            parity_err <= w_done & r_perr;
            frame_err  <= w_done & (r_ferr | ~w_maj);
            if (w_done) data_out <= r_shift;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench: three receiver configurations (8N1, 7E1,
//               8N2) driven by a behavioural serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 50_000_000;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_line [3];
    logic [2:0] baud    [3];
    logic       dv      [3];
    logic       pe      [3];
    logic       fe      [3];
    logic       busy    [3];
    logic [7:0] dout_a;
    logic [6:0] dout_b;
    logic [7:0] dout_c;

    rec_t q0[$], q1[$], q2[$];
    int   n_checks = 0, n_errors = 0;
    int   n_dbl = 0, n_unqual = 0, busy_cnt0 = 0;
    logic prev_dv [3] = '{1'b0, 1'b0, 1'b0};

    always #10 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .baud_set(baud[0]), .rs232_rx(rx_line[0]), .data_out(dout_a),
        .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]), .rx_busy(busy[0]));
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst(rst), .baud_set(baud[1]), .rs232_rx(rx_line[1]), .data_out(dout_b),
        .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]), .rx_busy(busy[1]));
    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .rst(rst), .baud_set(baud[2]), .rs232_rx(rx_line[2]), .data_out(dout_c),
        .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]), .rx_busy(busy[2]));

    function automatic logic [8:0] get_dout(input int idx);
        case (idx)
            0:       return {1'b0, dout_a};
            1:       return {2'b0, dout_b};
            default: return {1'b0, dout_c};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dv[i]) begin
                case (i)
                    0:       q0.push_back({get_dout(i), pe[i], fe[i]});
                    1:       q1.push_back({get_dout(i), pe[i], fe[i]});
                    default: q2.push_back({get_dout(i), pe[i], fe[i]});
                endcase
            end
            if (dv[i] && prev_dv[i]) n_dbl++;
            if (!dv[i] && (pe[i] || fe[i])) n_unqual++;
            prev_dv[i] = dv[i];
        end
        if (busy[0]) busy_cnt0++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_nbits(input int idx);
        return (idx == 1) ? 7 : 8;
    endfunction
    function automatic int cfg_nstop(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    function automatic int bclk(input logic [2:0] sel);
        int rate;
        case (sel)
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            3'd4:    rate = 115200;
            default: rate = 9600;
        endcase
        return CLK_FREQ / rate;
    endfunction

    // Reference: what a correct receiver reports for the frame as transmitted.
    function automatic rec_t model(input int idx, input logic [8:0] data, input bit pbit, input bit [1:0] stops);
        rec_t r;
        int   ones = 0;
        for (int k = 0; k < cfg_nbits(idx); k++) ones += int'(data[k]);
        r.data = data & ((9'h1 << cfg_nbits(idx)) - 9'h1);
        r.pe   = (idx == 1) && (((ones + int'(pbit)) % 2) != 0);
        r.fe   = (stops[0] == 1'b0) || ((cfg_nstop(idx) == 2) && (stops[1] == 1'b0));
        return r;
    endfunction

    task automatic wait_bits(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input bit pbit,
                              input bit [1:0] stops, input int bit_clk);
        rx_line[idx] = 1'b0;
        wait_bits(bit_clk);
        for (int k = 0; k < cfg_nbits(idx); k++) begin
            rx_line[idx] = data[k];
            wait_bits(bit_clk);
        end
        if (idx == 1) begin
            rx_line[idx] = pbit;
            wait_bits(bit_clk);
        end
        for (int s = 0; s < cfg_nstop(idx); s++) begin
            rx_line[idx] = stops[s];
            wait_bits(bit_clk);
        end
        rx_line[idx] = 1'b1;
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic get_rec(input int idx, input int limit, output rec_t r, output bit ok);
        ok = 1'b0;
        r  = '0;
        for (int n = 0; n < limit; n++) begin
            if (qsize(idx) != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            case (idx)
                0:       r = q0.pop_front();
                1:       r = q1.pop_front();
                default: r = q2.pop_front();
            endcase
        end
    endtask

    task automatic expect_rec(input int idx, input string tag, input rec_t exp, input int limit);
        rec_t r;
        bit   ok;
        get_rec(idx, limit, r, ok);
        check({tag, "_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            check({tag, "_data"}, 32'(r.data), 32'(exp.data));
            check({tag, "_perr"}, 32'(r.pe), 32'(exp.pe));
            check({tag, "_ferr"}, 32'(r.fe), 32'(exp.fe));
        end
    endtask

    task automatic send_check(input int idx, input string tag, input logic [8:0] data,
                              input bit pbit, input bit [1:0] stops, input logic [2:0] sel);
        baud[idx] = sel;
        wait_bits(4);
        send_frame(idx, data, pbit, stops, bclk(sel));
        expect_rec(idx, tag, model(idx, data, pbit, stops), 2 * bclk(sel));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        for (int i = 0; i < 3; i++) begin
            rx_line[i] = 1'b1;
            baud[i]    = 3'd0;
        end
        #5 rst = 1'b1;
        wait_bits(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_dv",   32'(dv[0]),  32'd0);
        check("rst_perr", 32'(pe[0]),  32'd0);
        check("rst_ferr", 32'(fe[0]),  32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);

        fork
            begin : g_a_slow
                b0 = busy_cnt0;
                send_check(0, "t1_8n1", 9'h018, 1'b0, 2'b11, 3'd0);
                check("t1_busy_len", 32'((busy_cnt0 - b0) >= 45000 && (busy_cnt0 - b0) <= 53000), 32'd1);
                check("t1_single", 32'(q0.size()), 32'd0);
            end
            begin : g_b_parity
                send_check(1, "par_bad", 9'h007, 1'b0, 2'b11, 3'd3);
                send_check(1, "par_good", 9'h007, 1'b1, 2'b11, 3'd3);
                for (int n = 0; n < 3; n++)
                    send_check(1, "par_rand", 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'b11, 3'd3);
                baud[1] = 3'd0;
                wait_bits(4);
                rx_line[1] = 1'b0;
                wait_bits(3);
                rx_line[1] = 1'b1;
                wait_bits(6);
                check("glitch_busy_hi", 32'(busy[1]), 32'd1);
                wait_bits(bclk(3'd0));
                check("glitch_busy_lo", 32'(busy[1]), 32'd0);
                check("glitch_no_dv", 32'(q1.size()), 32'd0);
            end
            begin : g_c_stop
                send_check(2, "stop2_bad", 9'h0A5, 1'b0, 2'b01, 3'd3);
                send_check(2, "stop2_next", 9'h03C, 1'b0, 2'b11, 3'd3);
                for (int n = 0; n < 3; n++)
                    send_check(2, "stop_rand", 9'($urandom_range(0, 255)), 1'b0, 2'($urandom_range(0, 3)), 3'd3);
            end
        join

        baud[0] = 3'd4;
        wait_bits(4);
        send_frame(0, 9'h055, 1'b0, 2'b11, bclk(3'd4));
        send_frame(0, 9'h0AA, 1'b0, 2'b11, bclk(3'd4));
        expect_rec(0, "b2b_first",  model(0, 9'h055, 1'b0, 2'b11), 2 * bclk(3'd4));
        expect_rec(0, "b2b_second", model(0, 9'h0AA, 1'b0, 2'b11), 2 * bclk(3'd4));

        wait_bits(bclk(3'd4));
        fork
            send_frame(0, 9'h0F0, 1'b0, 2'b11, bclk(3'd4));
            begin
                wait_bits(bclk(3'd4) * 7);
                rst = 1'b1;
                wait_bits(2);
                check("midrst_dout", 32'(dout_a), 32'd0);
                check("midrst_dv",   32'(dv[0]), 32'd0);
                check("midrst_busy", 32'(busy[0]), 32'd0);
                rst = 1'b0;
            end
        join
        wait_bits(bclk(3'd4));
        check("midrst_no_dv", 32'(q0.size()), 32'd0);
        send_check(0, "after_rst", 9'h081, 1'b0, 2'b11, 3'd4);
        for (int n = 0; n < 2; n++)
            send_check(0, "a_rand", 9'($urandom_range(0, 255)), 1'b0, 2'b11, 3'd4);

        wait_bits(20);
        check("dv_one_cycle", 32'(n_dbl), 32'd0);
        check("err_qualified", 32'(n_unqual), 32'd0);
        check("no_extra_dv", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
